// File: rtl/divider_iter_sched.sv
// Two-requester scheduler around one shared radix-2 restoring divide step, iterated N times per op.
// Define DIVSCHED_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module divider_iter_sched #(
    parameter int N = 4,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_dividend,
    input  logic [M-1:0] req0_divisor,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_dividend,
    input  logic [M-1:0] req1_divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_id,
    output logic [N-1:0] out_quotient,
    output logic [M-1:0] out_remainder,
    output logic         out_dz,
    output logic         busy
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   d_q, q_q;
    logic [M-1:0]   v_q;
    logic [M:0]     r_q;
    logic [CW-1:0]  cnt_q;
    logic           id_q, dz_q, last_grant;

    logic           grant, accept;
    logic [N-1:0]   sel_dividend;
    logic [M-1:0]   sel_divisor;
    logic [N+M-1:0] dividend_ext;
    logic [M:0]     p, diff;
    logic           take;

    always_comb begin
        grant = req1_valid & ~req0_valid;
        if (req0_valid && req1_valid) begin
`ifdef DIVSCHED_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end
    end

`ifndef DIVSCHED_ROUND_ROBIN_EN
    // Pointer is still tracked in the fixed-priority build so both builds share state behaviour.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Readies are gated by rstn so nothing is accepted while reset is held.
    assign accept       = rstn && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready   = accept && !grant;
    assign req1_ready   = accept && grant;
    assign sel_dividend = grant ? req1_dividend : req0_dividend;
    assign sel_divisor  = grant ? req1_divisor  : req0_divisor;
    assign dividend_ext = {{M{1'b0}}, sel_dividend};

    assign p    = {r_q[M-1:0], d_q[N-1]};
    assign take = (p >= {1'b0, v_q});
    assign diff = p - {1'b0, v_q};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (sel_divisor == '0) ? DONE : ITER;
            ITER:    if (cnt_q == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d_q        <= '0;
            q_q        <= '0;
            v_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            id_q       <= 1'b0;
            dz_q       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_q        <= sel_dividend;
                        v_q        <= sel_divisor;
                        id_q       <= grant;
                        last_grant <= grant;
                        cnt_q      <= CW'(N - 1);
                        if (sel_divisor == '0) begin
                            q_q  <= '1;
                            r_q  <= {1'b0, dividend_ext[M-1:0]};
                            dz_q <= 1'b1;
                        end else begin
                            q_q  <= '0;
                            r_q  <= '0;
                            dz_q <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    r_q <= take ? diff : p;
                    q_q <= {q_q[N-2:0], take};
                    d_q <= d_q << 1;
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // The partial remainder always ends below the divisor, so its top bit never reaches the output.
    logic unused_r_msb;
    assign unused_r_msb = r_q[M];

    assign out_valid     = (state == DONE);
    assign busy          = (state != IDLE);
    assign out_id        = id_q;
    assign out_quotient  = q_q;
    assign out_remainder = r_q[M-1:0];
    assign out_dz        = dz_q;
endmodule

// File: tb/tb_divider_iter_sched.sv
// Bench for divider_iter_sched: vector table, scoreboard monitor, and multi-cycle corner sequences.
module tb_divider_iter_sched;
    localparam int N = 4;
    localparam int M = 3;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_dividend = '0, req1_dividend = '0;
    logic [M-1:0] req0_divisor = '0, req1_divisor = '0;
    logic         out_valid, out_id, out_dz, busy;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_quotient;
    logic [M-1:0] out_remainder;

    always #5 clk = ~clk;

    divider_iter_sched #(.N(N), .M(M)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dz(out_dz), .busy(busy)
    );

    typedef struct packed {
        logic         id;
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         dz;
    } res_t;

    typedef struct {
        logic         id;
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [N-1:0] eq;
        logic [M-1:0] er;
        logic         edz;
        int           elat;
    } vec_t;

    res_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic res_t mk(input logic id, input logic [N-1:0] a, input logic [M-1:0] b);
        res_t e;
        if (b == '0) begin
            e = {id, {N{1'b1}}, a[M-1:0], 1'b1};
        end else begin
            e.id = id;
            e.q  = N'(int'(a) / int'(b));
            e.r  = M'(int'(a) % int'(b));
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor: pops one expectation per result handshake.
    always @(negedge clk) begin : monitor
        res_t e;
        if (rstn) begin
            if (busy) check("no_accept_while_busy", 32'({req0_ready, req1_ready}), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'({out_id, out_quotient, out_remainder, out_dz}), 32'h1ff);
                end else begin
                    e = sb.pop_front();
                    check("result{id,q,r,dz}", 32'({out_id, out_quotient, out_remainder, out_dz}), 32'(e));
                end
            end
        end
    end

    task automatic issue(input logic id, input logic [N-1:0] a, input logic [M-1:0] b,
                         input res_t e, input int elat);
        int lat;
        bit got;
        if (id) begin
            req1_valid = 1'b1; req1_dividend = a; req1_divisor = b;
        end else begin
            req0_valid = 1'b1; req0_dividend = a; req0_divisor = b;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1'b1;
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_dividend = N'($urandom); req0_divisor = M'($urandom);
        req1_dividend = N'($urandom); req1_divisor = M'($urandom);
        check("handshake", 32'(got), 32'd1);
        if (!got) return;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("latency", 32'(lat), 32'(elat));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 80 && sb.size() != 0; c++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    vec_t vecs[6];
    bit   got;
    logic g;

    initial begin
        vecs[0] = '{1'b0, 4'd13, 3'd3, 4'd4,  3'd1, 1'b0, 5};
        vecs[1] = '{1'b1, 4'd7,  3'd0, 4'hF,  3'd7, 1'b1, 1};
        vecs[2] = '{1'b0, 4'd0,  3'd5, 4'd0,  3'd0, 1'b0, 5};
        vecs[3] = '{1'b1, 4'd15, 3'd1, 4'd15, 3'd0, 1'b0, 5};
        vecs[4] = '{1'b0, 4'd9,  3'd0, 4'hF,  3'd1, 1'b1, 1};
        vecs[5] = '{1'b1, 4'd6,  3'd7, 4'd0,  3'd6, 1'b0, 5};

        // Reset state with a requester already valid.
        req0_valid = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'({out_valid, out_id, out_quotient, out_remainder, out_dz, busy,
                                    req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            issue(vecs[i].id, vecs[i].a, vecs[i].b,
                  {vecs[i].id, vecs[i].eq, vecs[i].er, vecs[i].edz}, vecs[i].elat);

        // Contention: last grant is requester 1 before the ties start.
        issue(1'b1, 4'd3, 3'd2, mk(1'b1, 4'd3, 3'd2), 5);
        req0_valid = 1'b1; req0_dividend = 4'd11; req0_divisor = 3'd2;
        req1_valid = 1'b1; req1_dividend = 4'd11; req1_divisor = 3'd2;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    got = 1'b1;
                    g = req1_ready;
                    check("single_grant", 32'(req0_ready & req1_ready), 32'd0);
`ifdef DIVSCHED_ROUND_ROBIN_EN
                    check("tie_grant_id", 32'(g), 32'(k % 2));
`else
                    check("tie_grant_id", 32'(g), 32'd0);
`endif
                    sb.push_back({g, 4'd5, 3'd1, 1'b0});
                end
                @(posedge clk); #1;
            end
            check("tie_handshake", 32'(got), 32'd1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Backpressure hold, then a waiting requester is granted right after the accept.
        out_ready = 1'b0;
        issue(1'b0, 4'd9, 3'd4, {1'b0, 4'd2, 3'd1, 1'b0}, 5);
        req1_valid = 1'b1; req1_dividend = 4'd5; req1_divisor = 3'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold{valid,q,r,rdy0,rdy1}", 32'({out_valid, out_quotient, out_remainder,
                                                    req0_ready, req1_ready}),
                  32'({1'b1, 4'd2, 3'd1, 2'b00}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("grant_after_accept", 32'(req1_ready), 32'd1);
        if (req1_ready) sb.push_back({1'b1, 4'd5, 3'd0, 1'b0});
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drain();

        // Reset mid-iteration discards the operation.
        req0_valid = 1'b1; req0_dividend = 4'd15; req0_divisor = 3'd7;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            got = req0_ready;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        check("reset_test_handshake", 32'(got), 32'd1);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("async_reset{busy,valid}", 32'({busy, out_valid}), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_dividend = 4'd15; req1_divisor = 3'd7;
        @(negedge clk);
        check("reset_outputs_mid", 32'({out_valid, out_id, out_quotient, out_remainder, out_dz, busy,
                                        req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("tie_after_reset{rdy0,rdy1}", 32'({req0_ready, req1_ready}), 32'b10);
        if (req0_ready) sb.push_back({1'b0, 4'd2, 3'd1, 1'b0});
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Exhaustive nonzero divisors against integer division.
        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 8; b++)
                issue(a[0], N'(a), M'(b), mk(a[0], N'(a), M'(b)), N + 1);

        drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
